// File: rtl/keypad_scan_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM encoding, key code map,
// column drive reset value and small row/column decode helpers.
package keypad_scan_pkg;

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_HELD,
        ST_RELEASE
    } state_t;

    localparam logic [3:0] COL_RESET = 4'b1110;

    // Indexed by {row, col}; row 0 is the top row, col 0 the left column.
    localparam logic [3:0] KEY_MAP [0:15] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    function automatic logic [1:0] low_index(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    function automatic logic is_single(input logic [3:0] v);
        return ($countones(~v) == 1);
    endfunction

    function automatic logic [3:0] col_rotl(input logic [3:0] v);
        return {v[2:0], v[3]};
    endfunction

endpackage

// File: rtl/keypad_scan_tick.sv
// scan_tick: free-running divider producing a one-clk pulse every
// CLK_HZ/SCAN_HZ clocks (never faster than every second clock).
module scan_tick #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int SCAN_HZ = 1_000
) (
    input  logic clk,
    input  logic rst,
    output logic o_tick
);
    localparam int DIV_RAW = CLK_HZ / SCAN_HZ;
    localparam int DIV     = (DIV_RAW < 2) ? 2 : DIV_RAW;
    localparam int CW      = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          r_tick;

    // NOTE: sequential state is written only with <= so every flop samples
    // the pre-edge values of its neighbours, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (r_cnt == LAST) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
            r_tick <= 1'b0;
        end
    end

    assign o_tick = r_tick;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner with per-key debounce and release filtering.
// Define KEYPAD_AUTOREPEAT_EN to re-pulse key_valid while a key stays held.
module keypad_scan
    import keypad_scan_pkg::*;
#(
    parameter int CLK_HZ         = 50_000_000,
    parameter int SCAN_HZ        = 1_000,
    parameter int DEBOUNCE_SCANS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       key_held
);
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [3:0]       r_row_meta, r_row_sync;
    logic             w_tick, w_none, w_single;
    state_t           r_state, w_state_next;
    logic [3:0]       r_col, w_col_next;
    logic [3:0]       r_pattern, w_pattern_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next, w_cnt_inc;
    logic [3:0]       r_key, w_key_next;
    logic             r_key_valid, w_valid_next;
    logic             r_key_held, w_held_next;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int REP_W = $clog2(4 * DEBOUNCE_SCANS + 1);
    localparam logic [REP_W-1:0] REP_FIRST = REP_W'(4 * DEBOUNCE_SCANS);
    localparam logic [REP_W-1:0] REP_NEXT  = REP_W'(DEBOUNCE_SCANS);

    logic [REP_W-1:0] r_rep_cnt, w_rep_cnt_next, w_rep_cnt_inc;
    logic             r_rep_first, w_rep_first_next;

    assign w_rep_cnt_inc = (r_rep_cnt == '1) ? r_rep_cnt : r_rep_cnt + 1'b1;
`endif

    scan_tick #(
        .CLK_HZ (CLK_HZ),
        .SCAN_HZ(SCAN_HZ)
    ) u_scan_tick (
        .clk   (clk),
        .rst   (rst),
        .o_tick(w_tick)
    );

    // Rows are asynchronous to clk; two flops before anything looks at them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_row_meta <= 4'hF;
            r_row_sync <= 4'hF;
        end else begin
            r_row_meta <= row;
            r_row_sync <= r_row_meta;
        end
    end

    assign w_none    = (r_row_sync == 4'hF);
    assign w_single  = is_single(r_row_sync);
    assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;

    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    always_comb begin
        w_state_next   = r_state;
        w_col_next     = r_col;
        w_pattern_next = r_pattern;
        w_cnt_next     = r_cnt;
        w_key_next     = r_key;
        w_valid_next   = 1'b0;
        w_held_next    = r_key_held;
`ifdef KEYPAD_AUTOREPEAT_EN
        w_rep_cnt_next   = r_rep_cnt;
        w_rep_first_next = r_rep_first;
`endif
        if (w_tick) begin
            unique case (r_state)
                ST_SCAN: begin
                    if (w_single) begin
                        w_pattern_next = r_row_sync;
                        w_cnt_next     = CNT_ONE;
                        w_state_next   = ST_DEBOUNCE;
                    end else begin
                        w_col_next = col_rotl(r_col);
                    end
                end
                ST_DEBOUNCE: begin
                    if (r_row_sync == r_pattern) begin
                        w_cnt_next = w_cnt_inc;
                        if (w_cnt_inc == CNT_MAX) begin
                            w_key_next   = KEY_MAP[{low_index(r_pattern), low_index(r_col)}];
                            w_valid_next = 1'b1;
                            w_held_next  = 1'b1;
                            w_cnt_next   = '0;
                            w_state_next = ST_HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
                            w_rep_cnt_next   = '0;
                            w_rep_first_next = 1'b1;
`endif
                        end
                    end else begin
                        w_cnt_next   = '0;
                        w_col_next   = col_rotl(r_col);
                        w_state_next = ST_SCAN;
                    end
                end
                ST_HELD: begin
                    if (w_none) begin
                        w_cnt_next   = CNT_ONE;
                        w_state_next = ST_RELEASE;
                    end
`ifdef KEYPAD_AUTOREPEAT_EN
                    else if (w_rep_cnt_inc == (r_rep_first ? REP_FIRST : REP_NEXT)) begin
                        w_valid_next     = 1'b1;
                        w_rep_cnt_next   = '0;
                        w_rep_first_next = 1'b0;
                    end else begin
                        w_rep_cnt_next = w_rep_cnt_inc;
                    end
`endif
                end
                ST_RELEASE: begin
                    if (w_none) begin
                        w_cnt_next = w_cnt_inc;
                        if (w_cnt_inc == CNT_MAX) begin
                            w_held_next  = 1'b0;
                            w_cnt_next   = '0;
                            w_col_next   = col_rotl(r_col);
                            w_state_next = ST_SCAN;
                        end
                    end else begin
                        w_cnt_next   = '0;
                        w_state_next = ST_HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
                        w_rep_cnt_next   = '0;
                        w_rep_first_next = 1'b1;
`endif
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_SCAN;
            r_col       <= COL_RESET;
            r_pattern   <= 4'hF;
            r_cnt       <= '0;
            r_key       <= 4'h0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            r_rep_cnt   <= '0;
            r_rep_first <= 1'b1;
`endif
        end else begin
            r_state     <= w_state_next;
            r_col       <= w_col_next;
            r_pattern   <= w_pattern_next;
            r_cnt       <= w_cnt_next;
            r_key       <= w_key_next;
            r_key_valid <= w_valid_next;
            r_key_held  <= w_held_next;
`ifdef KEYPAD_AUTOREPEAT_EN
            r_rep_cnt   <= w_rep_cnt_next;
            r_rep_first <= w_rep_first_next;
`endif
        end
    end

    assign col       = r_col;
    assign key       = r_key;
    assign key_valid = r_key_valid;
    assign key_held  = r_key_held;

endmodule
